// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: RV32I access-width codes, LSU state encoding and access legality rule.
package load_store_unit_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, RMW_WR} lsu_state_e;
  function automatic logic access_fault(input logic write, input logic [2:0] funct3, input logic [1:0] off);
    return funct3 == 3'b011 || funct3[2:1] == 2'b11 || (write && funct3[2]) ||
           (funct3[1:0] == F3_H[1:0] && off[0]) || (funct3[1:0] == F3_W[1:0] && off != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_unit_lane_logic.sv
// lsu_lane_logic: extracts/extends a load lane and merges store lanes into the memory word.
module lsu_lane_logic
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] mem_dout,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [31:0] shifted, mask, data;
  logic        sext;
  always_comb begin
    shifted   = mem_dout >> {off, 3'b000};
    sext      = funct3 == F3_B || funct3 == F3_H;
    load_data = (funct3 == F3_B || funct3 == F3_BU) ? {{24{sext & shifted[7]}}, shifted[7:0]} :
                (funct3 == F3_H || funct3 == F3_HU) ? {{16{sext & shifted[15]}}, shifted[15:0]} : mem_dout;
    mask      = funct3[1:0] == F3_B[1:0] ? 32'h0000_00ff << {off, 3'b000} :
                funct3[1:0] == F3_H[1:0] ? 32'h0000_ffff << {off, 3'b000} : '1;
    data      = funct3[1:0] == F3_B[1:0] ? {4{wdata[7:0]}} :
                funct3[1:0] == F3_H[1:0] ? {2{wdata[15:0]}} : wdata;
    merged    = (mem_dout & ~mask) | (data & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I MEM-stage LSU with read-modify-write for sub-word stores.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  lsu_state_e  state, state_nx;
  logic [31:0] load_data, merged, merged_q, waddr_q;
  logic        accept, bad, sub_st;
  lsu_lane_logic u_lane (
    .funct3   (funct3),
    .off      (addr[1:0]),
    .mem_dout (mem_dout),
    .wdata    (wdata),
    .load_data(load_data),
    .merged   (merged)
  );
  // A reset landing in RMW_WR suppresses the pending write in that same cycle.
  always_comb begin
    accept    = req_valid && state == IDLE && !reset;
    bad       = access_fault(req_write, funct3, addr[1:0]);
    sub_st    = req_write && funct3 != F3_W;
    req_ready = state == IDLE;
    mem_addr  = state == RMW_WR ? waddr_q : {addr[31:2], 2'b00};
    mem_read  = accept && !bad && (!req_write || sub_st);
    mem_write = state == RMW_WR ? !reset : accept && !bad && req_write && !sub_st;
    mem_din   = !mem_write ? '0 : state == RMW_WR ? merged_q : wdata;
    state_nx  = state == IDLE && accept && !bad && sub_st ? RMW_WR : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      fault       <= 1'b0;
      merged_q    <= '0;
      waddr_q     <= '0;
    end else begin
      state       <= state_nx;
      rdata_valid <= accept && !bad && !req_write;
      fault       <= accept && bad;
      if (accept && !bad && !req_write) rdata <= load_data;
      if (state_nx == RMW_WR) begin
        merged_q <= merged;
        waddr_q  <= mem_addr;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic        req_ready, rdata_valid, fault, mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_din, mem_dout;
  logic        mem_clr = 1'b0;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .req_ready(req_ready), .rdata(rdata), .rdata_valid(rdata_valid),
    .fault(fault), .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
    .mem_write(mem_write), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) for (int k = 0; k < 64; k++) mem[k] <= '0;
    else if (mem_write) mem[mem_addr[7:2]] <= mem_din;
  end

  function automatic logic ref_fault(input logic w, input logic [2:0] f3, input logic [1:0] off);
    int size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (w && f3 >= 3'd4)) return 1'b1;
    return (int'(off) % size) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] v = word >> (8 * int'(off));
    case (f3)
      3'd0: return {{24{v[7]}}, v[7:0]};
      3'd4: return {24'h0, v[7:0]};
      3'd1: return {{16{v[15]}}, v[15:0]};
      3'd5: return {16'h0, v[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    int nb = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    for (int i = 0; i < nb; i++) word[8 * (int'(off) + i) +: 8] = d[8 * i +: 8];
    return word;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid = v; req_write = w; funct3 = f3; addr = a; wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1;
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    step(); step();
    reset = 1'b0; mem_clr = 1'b0;
    for (int k = 0; k < 64; k++) ref_mem[k] = '0;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    tests++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    tests++; if (rdata_valid !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL reset_pulses got rv=%b f=%b exp 0 0", rdata_valid, fault); end
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_din !== 32'h0) begin fails++; $display("FAIL reset_mem got r=%b w=%b din=%h exp 0 0 0", mem_read, mem_write, mem_din); end
  endtask

  task automatic test_store_word();
    set_req(1, 1, 3'd2, 32'h10, 32'h8899AABB); #1;
    tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_din !== 32'h8899AABB || mem_addr !== 32'h10) begin fails++; $display("FAIL sw_accept got w=%b r=%b din=%h a=%h exp 1 0 8899aabb 10", mem_write, mem_read, mem_din, mem_addr); end
    step();
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    ref_mem[4] = 32'h8899AABB;
    tests++; if (mem[4] !== ref_mem[4]) begin fails++; $display("FAIL sw_mem got %h exp %h", mem[4], ref_mem[4]); end
    tests++; if (rdata_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL sw_no_resp got rv=%b rdy=%b exp 0 1", rdata_valid, req_ready); end
  endtask

  task automatic test_load_ext();
    set_req(1, 0, 3'd0, 32'h13, 32'h0); #1;
    tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h10) begin fails++; $display("FAIL lb_accept got r=%b w=%b a=%h exp 1 0 10", mem_read, mem_write, mem_addr); end
    step();
    set_req(1, 0, 3'd4, 32'h13, 32'h0);
    tests++; if (rdata_valid !== 1'b1 || rdata !== 32'hFFFFFF88) begin fails++; $display("FAIL lb_data got rv=%b %h exp 1 ffffff88", rdata_valid, rdata); end
    step();
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    tests++; if (rdata_valid !== 1'b1 || rdata !== 32'h00000088) begin fails++; $display("FAIL lbu_data got rv=%b %h exp 1 00000088", rdata_valid, rdata); end
    step();
    tests++; if (rdata_valid !== 1'b0 || rdata !== 32'h00000088) begin fails++; $display("FAIL rdata_hold got rv=%b %h exp 0 00000088", rdata_valid, rdata); end
  endtask

  task automatic test_rmw_then_load();
    set_req(1, 1, 3'd1, 32'h12, 32'h00001234); #1;
    tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL sh_accept got r=%b w=%b rdy=%b exp 1 0 1", mem_read, mem_write, req_ready); end
    step();
    set_req(1, 0, 3'd2, 32'h10, 32'h0); #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sh_hold got rdy=%b exp 0", req_ready); end
    tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_din !== 32'h1234AABB || mem_addr !== 32'h10) begin fails++; $display("FAIL sh_write got w=%b r=%b din=%h a=%h exp 1 0 1234aabb 10", mem_write, mem_read, mem_din, mem_addr); end
    step();
    ref_mem[4] = 32'h1234AABB;
    tests++; if (req_ready !== 1'b1 || mem_read !== 1'b1) begin fails++; $display("FAIL lw_after_sh got rdy=%b r=%b exp 1 1", req_ready, mem_read); end
    tests++; if (mem[4] !== ref_mem[4]) begin fails++; $display("FAIL sh_mem got %h exp %h", mem[4], ref_mem[4]); end
    step();
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    tests++; if (rdata_valid !== 1'b1 || rdata !== 32'h1234AABB) begin fails++; $display("FAIL lw_merged got rv=%b %h exp 1 1234aabb", rdata_valid, rdata); end
  endtask

  task automatic test_faults();
    logic        fw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  ff [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] fa [4] = '{32'h06, 32'h10, 32'h10, 32'h11};
    for (int i = 0; i < 4; i++) begin
      set_req(1, fw[i], ff[i], fa[i], 32'hFFFFFFFF); #1;
      tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL fault%0d_accept got r=%b w=%b rdy=%b exp 0 0 1", i, mem_read, mem_write, req_ready); end
      step();
      set_req(0, 0, 3'd0, 32'h0, 32'h0);
      tests++; if (fault !== 1'b1 || rdata_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL fault%0d_pulse got f=%b rv=%b rdy=%b exp 1 0 1", i, fault, rdata_valid, req_ready); end
      step();
      tests++; if (fault !== 1'b0) begin fails++; $display("FAIL fault%0d_clear got %b exp 0", i, fault); end
    end
    tests++; if (mem[4] !== ref_mem[4]) begin fails++; $display("FAIL fault_mem got %h exp %h", mem[4], ref_mem[4]); end
  endtask

  task automatic test_back_to_back();
    logic        bw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  bf [4] = '{3'd0, 3'd2, 3'd4, 3'd0};
    logic [31:0] ba [4] = '{32'h21, 32'h20, 32'h21, 32'h21};
    logic [31:0] ex [3] = '{32'h0000FF00, 32'h000000FF, 32'hFFFFFFFF};
    int held [4] = '{0, 0, 0, 0};
    logic [31:0] got [$];
    int i = 0, cyc = 0;
    while (i < 4 && cyc < 20) begin
      set_req(1, bw[i], bf[i], ba[i], 32'h000000FF); #1;
      if (req_ready) i++; else held[i]++;
      step(); cyc++;
      if (rdata_valid) got.push_back(rdata);
    end
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      if (rdata_valid) got.push_back(rdata);
    end
    tests++; if (i !== 4) begin fails++; $display("FAIL b2b_timeout got %0d accepted exp 4", i); end
    tests++; if (held[0] !== 0 || held[1] !== 1 || held[2] !== 0 || held[3] !== 0) begin fails++; $display("FAIL b2b_held got %0d %0d %0d %0d exp 0 1 0 0", held[0], held[1], held[2], held[3]); end
    tests++; if (got.size() !== 3) begin fails++; $display("FAIL b2b_count got %0d exp 3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      tests++; if (got[k] !== ex[k]) begin fails++; $display("FAIL b2b_data%0d got %h exp %h", k, got[k], ex[k]); end
    end
    ref_mem[8] = 32'h0000FF00;
    tests++; if (mem[8] !== ref_mem[8]) begin fails++; $display("FAIL b2b_mem got %h exp %h", mem[8], ref_mem[8]); end
  endtask

  task automatic test_reset_in_rmw();
    set_req(1, 1, 3'd2, 32'h30, 32'h55555555); step();
    ref_mem[12] = 32'h55555555;
    set_req(1, 1, 3'd0, 32'h30, 32'h000000AB); step();
    reset = 1'b1;
    set_req(0, 0, 3'd0, 32'h0, 32'h0); #1;
    tests++; if (mem_write !== 1'b0 || mem_din !== 32'h0) begin fails++; $display("FAIL rst_rmw_write got w=%b din=%h exp 0 0", mem_write, mem_din); end
    step();
    reset = 1'b0; #1;
    tests++; if (req_ready !== 1'b1 || rdata !== 32'h0 || rdata_valid !== 1'b0 || fault !== 1'b0) begin fails++; $display("FAIL rst_rmw_regs got rdy=%b rd=%h rv=%b f=%b exp 1 0 0 0", req_ready, rdata, rdata_valid, fault); end
    tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_din !== 32'h0 || mem_addr !== 32'h0) begin fails++; $display("FAIL rst_rmw_mem got r=%b w=%b din=%h a=%h exp 0 0 0 0", mem_read, mem_write, mem_din, mem_addr); end
    tests++; if (mem[12] !== ref_mem[12]) begin fails++; $display("FAIL rst_rmw_word got %h exp %h", mem[12], ref_mem[12]); end
  endtask

  task automatic test_random();
    logic v = 0, w = 0, hold = 0, busy = 0, acc, flt, exp_rv = 0, exp_f = 0;
    logic [2:0]  f3 = 0;
    logic [31:0] a = 0, d = 0, exp_rd = 0, last_rd = 0;
    int bad_mem = 0;
    for (int n = 0; n < 600; n++) begin
      step();
      tests++; if (rdata_valid !== exp_rv || fault !== exp_f) begin fails++; $display("FAIL rnd%0d_pulse got rv=%b f=%b exp %b %b", n, rdata_valid, fault, exp_rv, exp_f); end
      if (exp_rv) last_rd = exp_rd;
      tests++; if (rdata !== last_rd) begin fails++; $display("FAIL rnd%0d_rdata got %h exp %h", n, rdata, last_rd); end
      if (!hold) begin
        v = $urandom_range(0, 3) != 0; w = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7)); a = $urandom_range(0, 255); d = $urandom;
      end
      set_req(v, w, f3, a, d); #1;
      acc = v && !busy;
      flt = ref_fault(w, f3, a[1:0]);
      tests++; if (req_ready !== !busy) begin fails++; $display("FAIL rnd%0d_ready got %b exp %b", n, req_ready, !busy); end
      tests++; if (mem_read !== (acc && !flt && (!w || f3[1:0] != 2'd2)) || mem_write !== (busy || (acc && !flt && w && f3[1:0] == 2'd2))) begin fails++; $display("FAIL rnd%0d_memctl got r=%b w=%b busy=%b acc=%b flt=%b", n, mem_read, mem_write, busy, acc, flt); end
      hold = v && busy;
      exp_rv = acc && !flt && !w;
      exp_f = acc && flt;
      if (exp_rv) exp_rd = ref_load(ref_mem[a[7:2]], f3, a[1:0]);
      if (acc && !flt && w) ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], f3, a[1:0], d);
      busy = acc && !flt && w && f3[1:0] != 2'd2;
    end
    set_req(0, 0, 3'd0, 32'h0, 32'h0);
    step(); step();
    for (int k = 0; k < 64; k++) if (mem[k] !== ref_mem[k]) bad_mem++;
    tests++; if (bad_mem !== 0) begin fails++; $display("FAIL rnd_mem got %0d differing words exp 0", bad_mem); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_ext();
    test_rmw_then_load();
    test_faults();
    test_back_to_back();
    test_reset_in_rmw();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; data path fixed at 32 bits; byte-addressed, little-endian.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  MEM-stage access request.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 funct3  in  3  RV32I width code: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 req_ready  out  1  request accepted this cycle when req_valid && req_ready.
REQ-011 rdata  out  32  extended load result.
REQ-012 rdata_valid  out  1  one-cycle pulse qualifying rdata.
REQ-013 fault  out  1  one-cycle pulse for a misaligned or illegal access.
REQ-014 mem_addr  out  32  word-aligned address to data memory.
REQ-015 mem_din  out  32  write data to data memory.
REQ-016 mem_read  out  1  data-memory read enable.
REQ-017 mem_write  out  1  data-memory write enable.
REQ-018 mem_dout  in  32  data-memory read data, valid in the same cycle (asynchronous read).

Function
REQ-019 FSM states SHALL be IDLE and RMW_WR; req_ready = (state == IDLE).
REQ-020 mem_addr SHALL be {addr[31:2],2'b00} in IDLE and the latched word address in RMW_WR.
REQ-021 Accepted load: drive mem_read=1 in the accept cycle, then register the extracted lane.
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend.
  - Response: rdata_valid=1 with that rdata exactly one cycle later (latency 1).
REQ-022 Accepted SW: mem_write=1 and mem_din=wdata in the accept cycle; state stays IDLE; no rdata_valid.
REQ-023 Accepted SB/SH: accept cycle drives mem_read=1 and latches mem_dout merged with wdata lane(s) at addr[1:0]; next state is RMW_WR.
REQ-024 In RMW_WR the block SHALL drive mem_write=1 and mem_din=merged word, hold req_ready=0, and return to IDLE next cycle.
REQ-025 Misalignment: a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL be a fault.
  - No mem_read or mem_write is driven.
  - fault=1 one cycle after acceptance; state stays IDLE.
REQ-026 funct3 011, 110, 111, and stores with funct3[2]=1, SHALL be treated as faults as in REQ-025.
REQ-027 Outside an access, mem_read, mem_write and mem_din SHALL be 0.
REQ-028 Back-to-back loads/SW SHALL be accepted every cycle.
REQ-029 A request arriving in RMW_WR SHALL be held off and is accepted in the following IDLE cycle.
REQ-030 Loads following a sub-word store to the same word SHALL return the merged data, because the write completes before the next acceptance.
REQ-031 rdata SHALL hold its last value when rdata_valid=0.

Reset
REQ-032 On reset: state=IDLE, rdata=0, rdata_valid=0, fault=0, latched word/address=0.
REQ-033 Reset asserted in RMW_WR SHALL abandon the pending write; mem_write=0 in the reset cycle.

Structure
REQ-034 funct3 encodings and state encodings SHALL live in the shared CPU constants package/header.
REQ-035 Lane extraction and store merging SHALL be one combinational sub-module, lsu_lane_logic; the FSM and registers stay in load_store_unit.

Verification
REQ-036 Bench pre-loads the word at 0x10 with 0x8899AABB.
  - LB addr 0x13 -> rdata=0xFFFFFF88, rdata_valid one cycle later.
  - LBU addr 0x13 -> rdata=0x00000088.
REQ-037 Starting from the REQ-036 word: SH addr 0x12, wdata 0x00001234.
  - req_ready low for 1 cycle.
  - Memory word becomes 0x1234AABB.
  - Immediate LW 0x10 returns 0x1234AABB.
REQ-038 LW addr 0x06 -> fault pulse, no mem_read/mem_write, req_ready stays 1.
REQ-039 SB addr 0x21, wdata 0xFF, followed by 3 back-to-back loads.
  - Second request held exactly one cycle.
  - Word 0x20 reads 0x0000FF00 from a zero-initialised memory.
REQ-040 Reset asserted during RMW_WR of SB 0x30 -> no write occurs, state IDLE, all outputs 0 next cycle.
REQ-041 funct3=011 load -> fault pulse, no memory access.
